inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction-memory interface.
- Accepts a byte stream, packs bytes big-endian into 32-bit instruction words, and writes them into instruction RAM starting at word address 0.
- Holds the CPU fetch path (pc_reg) while loading, so the memory is never read mid-write.
- Sits between the host/debug byte source and the instruction RAM write port.

Parameters:
ADDR_W, 6, word-address width of instruction RAM (2^ADDR_W words)
LEN_W, ADDR_W+1, width of the word-count input

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle load request
len  input  LEN_W  number of words to load
abort  input  1  cancel the load in progress
byte_valid  input  1  byte_data is valid
byte_data  input  8  incoming byte
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  RAM write strobe
mem_addr  output  ADDR_W  RAM word address
mem_wdata  output  32  RAM write data
busy  output  1  load in progress
done  output  1  one-cycle completion pulse
err  output  1  sticky error flag
cpu_hold  output  1  high while loading; gates pc_reg/ROM ce

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All outputs are 0, including mem_addr and mem_wdata.
  - Internal byte counter, word register, address and words_left are all 0.
- States: IDLE, RECV, WRITE, DONE, plus CHECK when the optional feature is enabled.
- IDLE:
  - start=1 with len>0: latch words_left=min(len, 2^ADDR_W), addr=0, byte_cnt=0, clear err, go to RECV.
  - start=1 with len=0: done=1 for the next cycle, no write, stay IDLE.
- RECV:
  - byte_ready=1; this is a combinational function of state.
  - On byte_valid&byte_ready: word={word[23:0],byte_data}, byte_cnt++.
  - The first byte received becomes word bits [31:24].
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=word, byte_ready=0.
  - Latency: 4th byte accepted in cycle N, write visible in cycle N+1.
  - Next cycle: addr++, words_left--, byte_cnt=0.
  - If words_left was 1, go to DONE (CHECK if enabled); otherwise go to RECV.
  - addr stops at 2^ADDR_W-1; it never wraps within one load because len is clamped.
- DONE: done=1 for one cycle, then IDLE.
- busy=cpu_hold=1 in every state except IDLE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next cycle the state is IDLE, err=1, done=0.
  - No write occurs, even if the 4th byte is accepted in the same cycle; abort wins.
  - abort in IDLE has no effect.
- err stays set until the next accepted start.
- Reset mid-load: immediate return to IDLE with all outputs 0. RAM contents already written are left as they are.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit sum of all accepted data bytes, mod 256, is cleared on start.
  - After the last WRITE the state moves to CHECK, with byte_ready=1, and accepts one extra byte.
  - If (sum + check byte) mod 256 == 0, go to DONE with err=0.
  - Otherwise go to DONE with err=1; done still pulses.
  - abort in CHECK behaves as in any other non-IDLE state.
- Undefined: the CHECK state and the sum register do not exist; err is set only by abort.

Decomposition:
- Shared package (cpu_defs):
  - state encoding constants.
  - INST_W=32, BYTE_W=8, BYTES_PER_WORD=4.
  - default instruction-RAM ADDR_W=6, shared with pc_reg/rom.
- One natural sub-module: word_packer.
  - Contains the shift register and 2-bit byte counter, with load/clear/full signals.
  - The FSM, address counter and checksum stay in inst_loader.

Test Plan:
- Load 1 word: len=1, bytes 3C,01,00,10 → one cycle with mem_we=1, mem_addr=0, mem_wdata=3C010010; done pulses 1 cycle after the write; busy 0 afterwards.
- Load 64 words with byte_valid toggling randomly: len=64 → 64 writes at addresses 0..63 in order, data matching the stream; len=100 is clamped to 64 writes.
- len=0 → done=1 one cycle after start; no mem_we; busy stays 0.
- abort in the same cycle as the 3rd byte of word 2 (len=4) → exactly 2 writes (addr 0,1), err=1, no done; the next start clears err.
- rst=0 asserted asynchronously mid-RECV → all outputs 0 immediately; after release a fresh len=1 load completes correctly.
- With INST_LOADER_CHECKSUM_EN: bytes 01,02,03,04 plus check byte F6 → done, err=0. Check byte F5 → done, err=1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction/byte widths, default instruction-RAM
// depth (shared with pc_reg/rom) and the instruction-loader state encoding.
// INST_LOADER_CHECKSUM_EN adds the CHECK state to the encoding.
package cpu_defs;

  localparam int INST_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int IMEM_ADDR_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef INST_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/inst_loader_word_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes in from the right so
// the first byte of a word ends up in bits [31:24]. full_o flags that the
// byte being loaded this cycle completes the word.
module word_packer
  import cpu_defs::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              full_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] word_q, word_d;

  // Next shift-register/counter value; clear has priority over load.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      word_d = {word_q[INST_W-BYTE_W-1:0], byte_i};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Packer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign full_o = load_i && !clear_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: packs a host byte stream into 32-bit words and writes
// them to instruction RAM from word address 0, holding the CPU meanwhile.
// INST_LOADER_CHECKSUM_EN adds a trailing checksum byte verified in CHECK.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready depends only on the state (RECV/CHECK),
// never on byte_valid; the source may raise byte_valid at any time and must
// hold byte_data stable while byte_valid is high and byte_ready is low.
module inst_loader
  import cpu_defs::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [2:0]        dbg_state
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              err_q, err_d;
  logic              zdone_q, zdone_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [INST_W-1:0] last_data_q, last_data_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [BYTE_W-1:0] chk_sum;
`endif

  logic              accept;
  logic              start_go;
  logic              abort_hit;
  logic              pk_clear;
  logic              pk_full;
  logic [INST_W-1:0] pk_word;

  assign accept    = byte_valid && byte_ready;
  assign start_go  = (state_q == S_IDLE) && start && (len != '0);
  assign abort_hit = abort && (state_q != S_IDLE);
  assign pk_clear  = start_go || abort_hit || (state_q == S_WRITE);
`ifdef INST_LOADER_CHECKSUM_EN
  assign chk_sum   = sum_q + byte_data;
`endif

  word_packer u_packer (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (accept && (state_q == S_RECV)),
    .clear_i (pk_clear),
    .byte_i  (byte_data),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

  // Next-state logic; abort from any busy state overrides everything else.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    left_d      = left_q;
    err_d       = err_q;
    zdone_d     = 1'b0;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            zdone_d = 1'b1;
          end else begin
            left_d  = (len > MAX_WORDS) ? MAX_WORDS : len;
            addr_d  = '0;
            err_d   = 1'b0;
            state_d = S_RECV;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
      end
      S_RECV: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (accept) sum_d = sum_q + byte_data;
`endif
        if (pk_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        last_addr_d = addr_q;
        last_data_d = pk_word;
        left_d      = left_q - LEN_W'(1);
        if (left_q == LEN_W'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RECV;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          err_d   = (chk_sum != '0);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      left_q      <= '0;
      err_q       <= 1'b0;
      zdone_q     <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      err_q       <= err_d;
      zdone_q     <= zdone_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Outside WRITE the RAM port shows the previous write's address/data.
`ifdef INST_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
`else
  assign byte_ready = (state_q == S_RECV);
`endif
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = mem_we ? addr_q : last_addr_q;
  assign mem_wdata = mem_we ? pk_word : last_data_q;
  assign busy      = (state_q != S_IDLE);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_DONE) || zdone_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: single-word load, full-depth loads with
// gapped byte_valid, length clamp, zero length, abort, async reset and
// (with INST_LOADER_CHECKSUM_EN) the checksum byte.
module tb_inst_loader;

  localparam int ADDR_W = 6;
  localparam int LEN_W  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, mem_we, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        dbg_state;

  inst_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int extra_wr = 0;
  int done_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [7:0] tb_sum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every RAM write is matched against the next expected {addr,data}.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("mem_write", 64'({mem_addr, mem_wdata}), 64'(mon_e));
      end else begin
        extra_wr++;
      end
    end
    if (rst && done) done_cnt++;
  end

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b + 8'h40, b ^ 8'hA5, 8'hFF - b};
  endfunction

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic do_start(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(negedge clk);
    start  = 1'b0;
    tb_sum = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 20 && !byte_ready; t++) @(negedge clk);
    check("byte_ready", 64'(byte_ready), 64'(1));
    tb_sum = tb_sum + b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(0, maxgap));
  endtask

  // Ends on the negedge where done should be high.
  task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'h00 - tb_sum;
    send_byte(c, 0);
`else
    @(negedge clk);
`endif
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 50 && busy; t++) @(negedge clk);
    check("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold}), 64'(0));
    check("dbg_state_idle", 64'(dbg_state), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int w0;
    logic [31:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);

    // Single word 3C010010
    exp_q.push_back({6'd0, 32'h3C010010});
    do_start(1);
    check("t1_busy_hold", 64'({busy, cpu_hold}), 64'(2'b11));
    send_word(32'h3C010010, 0);
    check("t1_we", 64'(mem_we), 64'(1));
    check("t1_addr", 64'(mem_addr), 64'(0));
    check("t1_wdata", 64'(mem_wdata), 64'(32'h3C010010));
    check("t1_ready_in_write", 64'(byte_ready), 64'(0));
    finish_load();
    check("t1_done", 64'(done), 64'(1));
    check("t1_we_off", 64'(mem_we), 64'(0));
    check("t1_wdata_hold", 64'(mem_wdata), 64'(32'h3C010010));
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'(0));
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_exp_drained", 64'(exp_q.size()), 64'(0));
    check("t1_extra_wr", 64'(extra_wr), 64'(0));

    // Full depth (64) and clamped (100) loads with gapped byte_valid
    for (int pass = 0; pass < 2; pass++) begin
      d0 = done_cnt;
      for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), word_of(i + 64 * pass)});
      do_start(pass == 0 ? 64 : 100);
      for (int i = 0; i < 64; i++) send_word(word_of(i + 64 * pass), 2);
      finish_load();
      check("t2_done", 64'(done), 64'(1));
      wait_idle();
      check("t2_exp_drained", 64'(exp_q.size()), 64'(0));
      check("t2_extra_wr", 64'(extra_wr), 64'(0));
      check("t2_done_count", 64'(done_cnt - d0), 64'(1));
      check("t2_last_addr", 64'(mem_addr), 64'(63));
      check("t2_err", 64'(err), 64'(0));
    end

    // len = 0
    d0 = done_cnt;
    w0 = extra_wr;
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    check("t3_done", 64'(done), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("t3_done_pulse", 64'(done), 64'(0));
    check("t3_busy_after", 64'(busy), 64'(0));
    check("t3_done_count", 64'(done_cnt - d0), 64'(1));
    check("t3_no_write", 64'(extra_wr - w0), 64'(0));

    // Abort alongside 3rd byte of word 2, len = 4
    exp_q.push_back({6'd0, word_of(10)});
    exp_q.push_back({6'd1, word_of(11)});
    do_start(4);
    send_word(word_of(10), 1);
    send_word(word_of(11), 1);
    w = word_of(12);
    send_byte(w[31:24], 0);
    send_byte(w[23:16], 0);
    d0 = done_cnt;
    w0 = extra_wr;
    byte_data  = w[15:8];
    byte_valid = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    abort      = 1'b0;
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_err", 64'(err), 64'(1));
    check("t4_done", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check("t4_no_done", 64'(done_cnt - d0), 64'(0));
    check("t4_exp_drained", 64'(exp_q.size()), 64'(0));
    check("t4_no_extra", 64'(extra_wr - w0), 64'(0));
    check("t4_err_sticky", 64'(err), 64'(1));
    // abort in IDLE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_idle_abort", 64'({busy, err}), 64'(2'b01));
    do_start(1);
    check("t4_err_cleared", 64'(err), 64'(0));
    exp_q.push_back({6'd0, 32'hCAFE0123});
    send_word(32'hCAFE0123, 1);
    finish_load();
    wait_idle();
    check("t4_reload_drained", 64'(exp_q.size()), 64'(0));

    // Abort alongside the 4th byte: no write
    w0 = extra_wr;
    do_start(1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    byte_data  = 8'h44;
    byte_valid = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    abort      = 1'b0;
    check("t4b_no_we", 64'(mem_we), 64'(0));
    check("t4b_state", 64'({busy, err}), 64'(2'b01));
    repeat (2) @(negedge clk);
    check("t4b_no_write", 64'(extra_wr - w0), 64'(0));

    // Asynchronous reset mid-RECV
    exp_q.push_back({6'd0, word_of(20)});
    do_start(2);
    send_word(word_of(20), 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    #3 rst = 1'b0;
    #1 check_all_zero("t5_async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_exp_drained", 64'(exp_q.size()), 64'(0));
    exp_q.push_back({6'd0, 32'hDEADBEEF});
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    finish_load();
    check("t5_done", 64'(done), 64'(1));
    wait_idle();
    check("t5_reload_drained", 64'(exp_q.size()), 64'(0));
    check("t5_err", 64'(err), 64'(0));

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum: 01+02+03+04 = 0A; F6 passes, F5 fails
    exp_q.push_back({6'd0, 32'h01020304});
    do_start(1);
    send_word(32'h01020304, 0);
    send_byte(8'hF6, 0);
    check("ck_good_done", 64'(done), 64'(1));
    check("ck_good_err", 64'(err), 64'(0));
    wait_idle();
    exp_q.push_back({6'd0, 32'h01020304});
    do_start(1);
    send_word(32'h01020304, 0);
    send_byte(8'hF5, 0);
    check("ck_bad_done", 64'(done), 64'(1));
    check("ck_bad_err", 64'(err), 64'(1));
    wait_idle();
    check("ck_drained", 64'(exp_q.size()), 64'(0));
`endif

    check("final_extra_wr", 64'(extra_wr), 64'(0));
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
